// File: rtl/jtframe_pocket_bridge_mux_pkg.sv
// Shared constants and helpers for the Pocket bridge-bus router: fallback read value,
// standard APF window map, read FSM states and the byte-swap used for endian fixes.
package jtframe_pocket_bridge_mux_pkg;

  localparam logic [31:0] BRIDGE_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] CMD_BASE       = 32'hF8000000;
  localparam logic [31:0] USER_BASE      = 32'h10000000;
  localparam logic [31:0] WINDOW_MASK    = 32'hFF000000;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } rdState_t;

  function automatic logic [31:0] byteSwap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // A single channel still needs a one-bit index
  function automatic int chBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_pocket_bridge_mux_if.sv
// Bridge-side and device-side bus bundle of the router. The master modport is the
// APF bridge plus devices; the slave modport is the router itself.
interface jtframe_pocket_bridge_mux_if #(
  parameter int CH = 4
);

  logic [31:0]      bridge_addr;
  logic             bridge_rd;
  logic             bridge_wr;
  logic [31:0]      bridge_wr_data;
  logic [31:0]      bridge_rd_data;
  logic [31:0]      dev_addr;
  logic [31:0]      dev_wr_data;
  logic [CH-1:0]    dev_wr;
  logic [CH-1:0]    dev_rd;
  logic [CH*32-1:0] dev_rd_data;
  logic [CH-1:0]    dev_rd_ok;
  logic             busy;
  logic [7:0]       err_cnt;

  modport master (
    output bridge_addr, bridge_rd, bridge_wr, bridge_wr_data, dev_rd_data, dev_rd_ok,
    input  bridge_rd_data, dev_addr, dev_wr_data, dev_wr, dev_rd, busy, err_cnt
  );

  modport slave (
    input  bridge_addr, bridge_rd, bridge_wr, bridge_wr_data, dev_rd_data, dev_rd_ok,
    output bridge_rd_data, dev_addr, dev_wr_data, dev_wr, dev_rd, busy, err_cnt
  );

endinterface

// File: rtl/jtframe_pocket_bridge_dec.sv
// CH-way address window decoder: reports a hit, the lowest matching channel index
// and the address offset inside that window.
module jtframe_pocket_bridge_dec
  import jtframe_pocket_bridge_mux_pkg::*;
#(
  parameter int               CH   = 4,
  parameter int               CHW  = 2,
  parameter logic [CH*32-1:0] BASE = {CH{32'h0}},
  parameter logic [CH*32-1:0] MASK = {CH{WINDOW_MASK}}
) (
  input  logic [31:0]    i_addr,
  output logic           o_hit,
  output logic [CHW-1:0] o_ch,
  output logic [31:0]    o_offset
);

  // Scanning downwards lets the lowest matching window overwrite higher ones
  always_comb begin
    o_hit    = 1'b0;
    o_ch     = '0;
    o_offset = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if ((i_addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
        o_hit    = 1'b1;
        o_ch     = CHW'(i);
        o_offset = i_addr & ~MASK[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/jtframe_pocket_bridge_mux.sv
// Analogue Pocket bridge-bus router: forwards writes as one-cycle strobes and sequences
// reads with per-device acknowledge, timeout, optional byte swap and an error counter.
module jtframe_pocket_bridge_mux
  import jtframe_pocket_bridge_mux_pkg::*;
#(
  parameter int               CH      = 4,
  parameter logic [CH*32-1:0] BASE    = {CH{32'h0}},
  parameter logic [CH*32-1:0] MASK    = {CH{WINDOW_MASK}},
  parameter logic [CH-1:0]    SWAP    = {CH{1'b0}},
  parameter int               TIMEOUT = 15,
  parameter logic [31:0]      DEFAULT = BRIDGE_DEFAULT
) (
  input logic                        clk_74a,
  input logic                        reset_n,
  jtframe_pocket_bridge_mux_if.slave bus
);

  localparam int CHW = chBits(CH);

  logic           w_hit;
  logic [CHW-1:0] w_ch;
  logic [31:0]    w_offset;
  logic           w_rdMiss;
  logic           w_wrMiss;
  logic           w_selOk;
  logic [31:0]    w_selData;
  logic           w_timeout;
  logic [9:0]     w_errSum;

  rdState_t       r_state;
  logic [CHW-1:0] r_rdCh;
  logic [7:0]     r_timer;
  logic [CH-1:0]  r_devRd;
  logic [CH-1:0]  r_devWr;
  logic [31:0]    r_devAddr;
  logic [31:0]    r_devWrData;
  logic [31:0]    r_rdData;
  logic           r_busy;
  logic [7:0]     r_errCnt;

  jtframe_pocket_bridge_dec #(
    .CH   (CH),
    .CHW  (CHW),
    .BASE (BASE),
    .MASK (MASK)
  ) u_dec (
    .i_addr   (bus.bridge_addr),
    .o_hit    (w_hit),
    .o_ch     (w_ch),
    .o_offset (w_offset)
  );

  assign w_rdMiss  = bus.bridge_rd & ~w_hit;
  assign w_wrMiss  = bus.bridge_wr & ~w_hit;
  assign w_selOk   = bus.dev_rd_ok[r_rdCh];
  assign w_selData = SWAP[r_rdCh] ? byteSwap(bus.dev_rd_data[32*r_rdCh +: 32])
                                  : bus.dev_rd_data[32*r_rdCh +: 32];
  // A new bridge read or an acknowledge in the final cycle both pre-empt the timeout
  assign w_timeout = (r_state == ST_WAIT) && !bus.bridge_rd && !w_selOk &&
                     (r_timer == 8'(TIMEOUT));
  assign w_errSum  = {2'b00, r_errCnt} + {9'd0, w_rdMiss} + {9'd0, w_wrMiss} + {9'd0, w_timeout};

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_devWr     <= '0;
      r_devWrData <= '0;
    end else begin
      r_devWr <= '0;
      if (bus.bridge_wr && w_hit) begin
        r_devWr[w_ch] <= 1'b1;
        r_devWrData   <= bus.bridge_wr_data;
      end
    end
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_rdCh    <= '0;
      r_timer   <= '0;
      r_devRd   <= '0;
      r_devAddr <= '0;
      r_rdData  <= DEFAULT;
      r_busy    <= 1'b0;
      r_errCnt  <= '0;
    end else begin
      r_devRd  <= '0;
      r_errCnt <= (w_errSum > 10'd255) ? 8'hFF : w_errSum[7:0];
      if ((bus.bridge_rd || bus.bridge_wr) && w_hit) begin
        r_devAddr <= w_offset;
      end
      // A bridge read restarts the sequence whether idle or still waiting
      if (bus.bridge_rd) begin
        if (w_hit) begin
          r_rdCh        <= w_ch;
          r_devRd[w_ch] <= 1'b1;
          r_timer       <= '0;
          r_state       <= ST_WAIT;
          r_busy        <= 1'b1;
        end else begin
          r_rdData <= DEFAULT;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
        end
      end else if (r_state == ST_WAIT) begin
        if (w_selOk) begin
          r_rdData <= w_selData;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
        end else if (w_timeout) begin
          r_rdData <= DEFAULT;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
        end else begin
          r_timer <= r_timer + 8'd1;
        end
      end
    end
  end

  assign bus.bridge_rd_data = r_rdData;
  assign bus.dev_addr       = r_devAddr;
  assign bus.dev_wr_data    = r_devWrData;
  assign bus.dev_wr         = r_devWr;
  assign bus.dev_rd         = r_devRd;
  assign bus.busy           = r_busy;
  assign bus.err_cnt        = r_errCnt;

endmodule
